puc_blk_packer: RTL and testbench
=================================

Name: puc_blk_packer

Overview:
- Downstream stage of the PUC data collector.
- Builds one 512-byte SD block (64 x 64-bit words) in the SDC host bus FIFO: word 0 is a time stamp, words 1..63 are PUC data words.
- Paces the collector by pulsing rdy_for_nxt_pkt once per data word. Pulses blk_rdy_strb when the block is complete so the single-block SD write can start.

Parameters:
- WORDS_PER_BLK, 64, total FIFO words per block, time stamp included.
- DW, 64, FIFO/data word width.
- TO_CYC, 1023, maximum cycles to wait for puc_data_strb after a request before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- strt_blk_strb  in  1  one-cycle pulse; start a new block
- time_stamp  in  64  current time stamp, sampled on an accepted strt_blk_strb
- puc_data  in  64  data word from the collector
- puc_data_strb  in  1  one-cycle pulse; puc_data valid
- rdy_for_nxt_pkt  out  1  one-cycle pulse; request next data word from the collector
- fifo_wr_data  out  64  FIFO write data
- fifo_wr_en  out  1  FIFO write enable, one cycle per word
- fifo_full  in  1  FIFO full; no write while high
- blk_rdy_strb  out  1  one-cycle pulse; all 64 words written
- wrd_cnt  out  7  words written in current block (0..64)
- busy  out  1  high from accepted start until return to IDLE
- timeout_err  out  1  sticky; set on data timeout, cleared by the next accepted strt_blk_strb

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, internal latches and timer 0.
- Reset asserted mid-block: immediate return to IDLE. The partial block is not flagged, and blk_rdy_strb is not pulsed.
- IDLE
  - busy=0.
  - On strt_blk_strb: latch time_stamp, clear wrd_cnt and timeout_err, go to WR_TS.
- WR_TS
  - If fifo_full=0: fifo_wr_en=1, fifo_wr_data=latched time stamp, wrd_cnt<=1, go to REQ.
  - Otherwise hold.
- REQ
  - rdy_for_nxt_pkt=1 for exactly one cycle, clear timer, go to WAIT_DATA.
- WAIT_DATA
  - On puc_data_strb: latch puc_data, go to WR_DATA.
  - Otherwise the timer increments. When timer==TO_CYC: set timeout_err, go to IDLE. No blk_rdy_strb, no further FIFO writes.
- WR_DATA
  - If fifo_full=0: fifo_wr_en=1, fifo_wr_data=latched word, wrd_cnt<=wrd_cnt+1.
  - After that write, if wrd_cnt+1==WORDS_PER_BLK go to DONE, else go to REQ.
  - If fifo_full=1: hold the latched word and do not write.
- DONE
  - blk_rdy_strb=1 for one cycle, go to IDLE.
- Counts and latency:
  - Exactly 63 rdy_for_nxt_pkt pulses and 64 fifo_wr_en pulses per complete block.
  - fifo_wr_en rises one cycle after the accepting state is entered, given fifo_full=0.
  - Minimum block time (fifo never full, collector latency L cycles): 2 + 63*(L+2) + 1 cycles.
- Ignored inputs:
  - strt_blk_strb while busy.
  - puc_data_strb outside WAIT_DATA; the word is dropped and no counters change.
- Simultaneous events:
  - puc_data_strb on the same cycle the timer reaches TO_CYC: data wins, no timeout.
  - fifo_full is sampled in the same cycle the write would be issued.
- wrd_cnt saturates at WORDS_PER_BLK and holds its value in IDLE until the next start.

Test Plan:
- Nominal block: reset released, strt_blk_strb with time_stamp=64'h0000_0000_1234_5678; collector model answers each rdy_for_nxt_pkt with puc_data_strb 4 cycles later, data {28'b0, 36'hA_0000_0000 + n}. Required: 64 fifo_wr_en pulses, first word 64'h0000_0000_1234_5678, word n = {28'b0, 36'hA_0000_0000+n}, 63 rdy pulses, one blk_rdy_strb, wrd_cnt=64, busy falls the cycle after blk_rdy_strb.
- FIFO back-pressure: hold fifo_full=1 for 10 cycles at word 0 and again at word 30. Required: no fifo_wr_en while full, no data loss or duplication, wrd_cnt stalls at 0 and at 30, block still completes with 64 writes.
- Timeout: collector stops responding after word 20. Required: after TO_CYC=1023 idle cycles in WAIT_DATA, timeout_err=1, busy=0, wrd_cnt=21, no blk_rdy_strb. The next strt_blk_strb clears timeout_err.
- Spurious inputs: puc_data_strb pulsed in IDLE and in REQ, strt_blk_strb pulsed at word 10. Required: no extra fifo_wr_en, no restart, final written contents identical to the nominal case.
- Reset mid-operation: assert reset at word 40. Required: all outputs 0 asynchronously, state IDLE. The following block completes normally with wrd_cnt=64.
- Boundary: puc_data_strb arrives exactly on the cycle the timer equals TO_CYC. Required: word is written, timeout_err stays 0.

Source files
------------

// File: rtl/puc_blk_packer.sv
`default_nettype none
// ============================================================================
//  Module   : puc_blk_packer
//  Purpose  : Packs one 512-byte SD block (time stamp + 63 PUC data words)
//             into the SDC host bus FIFO, pacing the upstream collector with
//             one request pulse per data word and flagging block completion.
//  Revision : 1.0  initial release
// ============================================================================
module puc_blk_packer #(
  parameter int WORDS_PER_BLK = 64,
  parameter int DW            = 64,
  parameter int TO_CYC        = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          strt_blk_strb,
  input  logic [DW-1:0] time_stamp,
  input  logic [DW-1:0] puc_data,
  input  logic          puc_data_strb,
  output logic          rdy_for_nxt_pkt,
  output logic [DW-1:0] fifo_wr_data,
  output logic          fifo_wr_en,
  input  logic          fifo_full,
  output logic          blk_rdy_strb,
  output logic [6:0]    wrd_cnt,
  output logic          busy,
  output logic          timeout_err
);

  localparam int          TW     = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TO_CYC);
  localparam logic [6:0]  WPB    = 7'(WORDS_PER_BLK);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_TS     = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_WR_DATA   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] ts_q, ts_d;
  logic [DW-1:0] data_q, data_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          rdy_q, rdy_d;
  logic          blk_rdy_q, blk_rdy_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          to_err_q, to_err_d;
  logic [6:0]    cnt_inc;

  assign cnt_inc = cnt_q + 7'd1;

  // State and registered-output update; reset drops any partial block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ts_q      <= '0;
      data_q    <= '0;
      timer_q   <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rdy_q     <= 1'b0;
      blk_rdy_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      data_q    <= data_d;
      timer_q   <= timer_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rdy_q     <= rdy_d;
      blk_rdy_q <= blk_rdy_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      to_err_q  <= to_err_d;
    end
  end

  // Next-state and next-output decode; pulses default low, the rest hold.
  always_comb begin
    state_d   = state_q;
    ts_d      = ts_q;
    data_d    = data_q;
    timer_d   = timer_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rdy_d     = 1'b0;
    blk_rdy_d = 1'b0;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    to_err_d  = to_err_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (strt_blk_strb) begin
          ts_d     = time_stamp;
          cnt_d    = '0;
          to_err_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_WR_TS;
        end
      end
      S_WR_TS: begin
        if (!fifo_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = ts_q;
          cnt_d     = 7'd1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        rdy_d   = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        // A strobe arriving on the final timer cycle still beats the timeout.
        if (puc_data_strb) begin
          data_d  = puc_data;
          state_d = S_WR_DATA;
        end else if (timer_q == TO_LIM) begin
          to_err_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WR_DATA: begin
        if (!fifo_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = data_q;
          if (cnt_q != WPB) begin
            cnt_d = cnt_inc;
          end
          state_d = (cnt_inc == WPB) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        // busy stays up through the blk_rdy_strb cycle and drops in IDLE.
        blk_rdy_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdy_for_nxt_pkt = rdy_q;
  assign fifo_wr_data    = wr_data_q;
  assign fifo_wr_en      = wr_en_q;
  assign blk_rdy_strb    = blk_rdy_q;
  assign wrd_cnt         = cnt_q;
  assign busy            = busy_q;
  assign timeout_err     = to_err_q;

endmodule
`default_nettype wire

// File: tb/tb_puc_blk_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_puc_blk_packer
//  Purpose  : Directed self-checking bench for puc_blk_packer: a cycle-stepped
//             collector/FIFO model drives each block, scenario tasks check it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_puc_blk_packer;

  localparam logic [35:0] BASE  = 36'hA_0000_0000;
  localparam logic [63:0] TS_A  = 64'h0000_0000_1234_5678;
  localparam logic [63:0] JUNK  = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        strt_blk_strb;
  logic [63:0] time_stamp;
  logic [63:0] puc_data;
  logic        puc_data_strb;
  logic        rdy_for_nxt_pkt;
  logic [63:0] fifo_wr_data;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        blk_rdy_strb;
  logic [6:0]  wrd_cnt;
  logic        busy;
  logic        timeout_err;

  int vec_n  = 0;
  int miss_n = 0;

  // scenario configuration
  int cfg_lat, cfg_stop, cfg_abort, cfg_bound_word;
  bit cfg_stall, cfg_spur;

  // per-block results
  logic [63:0] wr_q[$];
  int rdy_n, blk_n, viol_n, first_wr_cyc, blk_cyc, end_cyc, last_rdy_cyc;
  bit err_at_start, aborted;

  puc_blk_packer #(.WORDS_PER_BLK(64), .DW(64), .TO_CYC(1023)) dut (
    .clk             (clk),
    .reset           (reset),
    .strt_blk_strb   (strt_blk_strb),
    .time_stamp      (time_stamp),
    .puc_data        (puc_data),
    .puc_data_strb   (puc_data_strb),
    .rdy_for_nxt_pkt (rdy_for_nxt_pkt),
    .fifo_wr_data    (fifo_wr_data),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_full       (fifo_full),
    .blk_rdy_strb    (blk_rdy_strb),
    .wrd_cnt         (wrd_cnt),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic set_defaults();
    cfg_lat = 4; cfg_stop = 63; cfg_abort = 0; cfg_bound_word = 0;
    cfg_stall = 0; cfg_spur = 0;
  endtask

  // Starts a block and steps it cycle by cycle (called #1 after an edge).
  task automatic run_block(input logic [63:0] ts);
    int cyc, cd, resp_n, req_n, fullc;
    bit pend, seen_busy, st0, st30, sp_req, sp_strt, prev_full, done;
    wr_q.delete();
    rdy_n = 0; blk_n = 0; viol_n = 0; first_wr_cyc = 0; blk_cyc = 0;
    end_cyc = 0; last_rdy_cyc = 0; err_at_start = 0; aborted = 0;
    cyc = 0; cd = 0; resp_n = 0; req_n = 0; fullc = 0;
    pend = 0; seen_busy = 0; st0 = 0; st30 = 0; sp_req = 0; sp_strt = 0; done = 0;
    time_stamp = ts;
    strt_blk_strb = 1'b1;
    while (!done) begin
      prev_full = fifo_full;
      @(posedge clk); #1;
      cyc++;
      if (fifo_wr_en) begin
        wr_q.push_back(fifo_wr_data);
        if (first_wr_cyc == 0) first_wr_cyc = cyc;
        if (prev_full) viol_n++;
      end
      if (rdy_for_nxt_pkt) begin
        rdy_n++; req_n++; last_rdy_cyc = cyc;
        if (req_n <= cfg_stop) begin
          pend = 1; resp_n = req_n;
          cd = (req_n == cfg_bound_word) ? 1024 : cfg_lat;
        end
      end
      if (blk_rdy_strb) begin blk_n++; blk_cyc = cyc; end
      if (busy && !seen_busy) begin seen_busy = 1; err_at_start = timeout_err; end
      if (cfg_stall && busy && wrd_cnt == 7'd0 && !st0) begin st0 = 1; fullc = 10; end
      if (cfg_stall && wrd_cnt == 7'd30 && !st30) begin st30 = 1; fullc = 10; end
      strt_blk_strb = 1'b0;
      puc_data_strb = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          pend = 0; puc_data_strb = 1'b1; puc_data = {28'd0, BASE + 36'(resp_n)};
        end
      end
      if (cfg_spur && fifo_wr_en && wrd_cnt == 7'd5 && !sp_req) begin
        sp_req = 1; puc_data_strb = 1'b1; puc_data = JUNK;
      end
      if (cfg_spur && wrd_cnt == 7'd10 && !sp_strt) begin
        sp_strt = 1; strt_blk_strb = 1'b1; time_stamp = 64'hFFFF_0000_FFFF_0000;
      end
      fifo_full = (fullc > 0);
      if (fullc > 0) fullc--;
      if (seen_busy && !busy) begin
        done = 1; end_cyc = cyc;
      end else if (cfg_abort != 0 && int'(wrd_cnt) == cfg_abort) begin
        done = 1; aborted = 1;
      end else if (cyc >= 3000) begin
        done = 1; vec_n++; miss_n++;
        $display("FAIL block_budget: still busy after %0d cycles, required idle", cyc);
      end
    end
    strt_blk_strb = 1'b0;
    puc_data_strb = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vec_n++;
    if ({rdy_for_nxt_pkt, fifo_wr_en, blk_rdy_strb, busy, timeout_err, wrd_cnt, fifo_wr_data} !== '0) begin
      miss_n++;
      $display("FAIL reset_outputs: wrd_cnt=%0d busy=%0b wr_en=%0b data=%h, required all 0",
               wrd_cnt, busy, fifo_wr_en, fifo_wr_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int bad;
    set_defaults();
    run_block(TS_A);
    vec_n++; if (wr_q.size() != 64) begin miss_n++; $display("FAIL nom_writes: got %0d, required 64", wr_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== ((i == 0) ? TS_A : {28'd0, BASE + 36'(i)})) bad++;
    vec_n++; if (bad != 0) begin miss_n++; $display("FAIL nom_data: %0d bad words, required 0", bad); end
    vec_n++; if (rdy_n != 63) begin miss_n++; $display("FAIL nom_rdy: got %0d, required 63", rdy_n); end
    vec_n++; if (blk_n != 1) begin miss_n++; $display("FAIL nom_blk_rdy: got %0d, required 1", blk_n); end
    vec_n++; if (wrd_cnt !== 7'd64) begin miss_n++; $display("FAIL nom_wrd_cnt: got %0d, required 64", wrd_cnt); end
    vec_n++; if (first_wr_cyc != 2) begin miss_n++; $display("FAIL nom_first_wr: cycle %0d, required 2", first_wr_cyc); end
    vec_n++; if (blk_cyc != 381) begin miss_n++; $display("FAIL nom_blk_time: cycle %0d, required 381", blk_cyc); end
    vec_n++; if (end_cyc != blk_cyc + 1) begin miss_n++; $display("FAIL nom_busy_fall: cycle %0d, required %0d", end_cyc, blk_cyc + 1); end
    repeat (3) begin @(posedge clk); #1; end
    vec_n++;
    if (wrd_cnt !== 7'd64 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      miss_n++; $display("FAIL nom_idle_hold: wrd_cnt=%0d busy=%0b err=%0b, required 64/0/0", wrd_cnt, busy, timeout_err);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    set_defaults();
    cfg_stall = 1;
    run_block(TS_A);
    vec_n++; if (viol_n != 0) begin miss_n++; $display("FAIL bp_write_while_full: got %0d, required 0", viol_n); end
    vec_n++; if (wr_q.size() != 64) begin miss_n++; $display("FAIL bp_writes: got %0d, required 64", wr_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== ((i == 0) ? TS_A : {28'd0, BASE + 36'(i)})) bad++;
    vec_n++; if (bad != 0) begin miss_n++; $display("FAIL bp_data: %0d bad words, required 0", bad); end
    vec_n++; if (first_wr_cyc != 12) begin miss_n++; $display("FAIL bp_first_wr: cycle %0d, required 12", first_wr_cyc); end
    vec_n++; if (blk_cyc != 396) begin miss_n++; $display("FAIL bp_blk_time: cycle %0d, required 396", blk_cyc); end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_timeout();
    int extra;
    set_defaults();
    cfg_stop = 20;
    run_block(TS_A);
    vec_n++; if (timeout_err !== 1'b1) begin miss_n++; $display("FAIL to_err: got %0b, required 1", timeout_err); end
    vec_n++; if (busy !== 1'b0) begin miss_n++; $display("FAIL to_busy: got %0b, required 0", busy); end
    vec_n++; if (wrd_cnt !== 7'd21) begin miss_n++; $display("FAIL to_wrd_cnt: got %0d, required 21", wrd_cnt); end
    vec_n++; if (blk_n != 0) begin miss_n++; $display("FAIL to_blk_rdy: got %0d, required 0", blk_n); end
    vec_n++; if (end_cyc - last_rdy_cyc != 1024) begin miss_n++; $display("FAIL to_delay: got %0d, required 1024", end_cyc - last_rdy_cyc); end
    extra = 0;
    repeat (5) begin @(posedge clk); #1; if (fifo_wr_en) extra++; end
    vec_n++; if (extra != 0 || timeout_err !== 1'b1) begin
      miss_n++; $display("FAIL to_after: writes=%0d err=%0b, required 0/1", extra, timeout_err);
    end
    cfg_stop = 63;
    run_block(TS_A);
    vec_n++; if (err_at_start !== 1'b0) begin miss_n++; $display("FAIL to_clear_on_start: got %0b, required 0", err_at_start); end
    vec_n++; if (wr_q.size() != 64 || timeout_err !== 1'b0) begin
      miss_n++; $display("FAIL to_restart: writes=%0d err=%0b, required 64/0", wr_q.size(), timeout_err);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_spurious();
    int bad;
    set_defaults();
    puc_data = JUNK; puc_data_strb = 1'b1;
    @(posedge clk); #1;
    puc_data_strb = 1'b0;
    @(posedge clk); #1;
    vec_n++;
    if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || rdy_for_nxt_pkt !== 1'b0) begin
      miss_n++; $display("FAIL sp_idle_strb: wr_en=%0b busy=%0b rdy=%0b, required 0/0/0", fifo_wr_en, busy, rdy_for_nxt_pkt);
    end
    cfg_spur = 1;
    run_block(TS_A);
    vec_n++; if (wr_q.size() != 64) begin miss_n++; $display("FAIL sp_writes: got %0d, required 64", wr_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== ((i == 0) ? TS_A : {28'd0, BASE + 36'(i)})) bad++;
    vec_n++; if (bad != 0) begin miss_n++; $display("FAIL sp_data: %0d bad words, required 0", bad); end
    vec_n++; if (rdy_n != 63 || blk_n != 1) begin miss_n++; $display("FAIL sp_pulses: rdy=%0d blk=%0d, required 63/1", rdy_n, blk_n); end
    vec_n++; if (blk_cyc != 381) begin miss_n++; $display("FAIL sp_blk_time: cycle %0d, required 381", blk_cyc); end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid();
    int blk_seen;
    set_defaults();
    cfg_abort = 40;
    run_block(TS_A);
    vec_n++; if (aborted !== 1'b1) begin miss_n++; $display("FAIL rm_reach_40: aborted=%0b, required 1", aborted); end
    #2 reset = 1'b0;
    #1;
    vec_n++;
    if ({rdy_for_nxt_pkt, fifo_wr_en, blk_rdy_strb, busy, timeout_err, wrd_cnt, fifo_wr_data} !== '0) begin
      miss_n++;
      $display("FAIL rm_async_clear: wrd_cnt=%0d busy=%0b wr_en=%0b data=%h, required all 0",
               wrd_cnt, busy, fifo_wr_en, fifo_wr_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    blk_seen = 0;
    repeat (3) begin @(posedge clk); #1; if (blk_rdy_strb || busy || fifo_wr_en) blk_seen++; end
    vec_n++; if (blk_seen != 0) begin miss_n++; $display("FAIL rm_quiet: %0d active cycles, required 0", blk_seen); end
    cfg_abort = 0;
    run_block(TS_A);
    vec_n++; if (wr_q.size() != 64 || wrd_cnt !== 7'd64 || blk_n != 1) begin
      miss_n++; $display("FAIL rm_next_block: writes=%0d wrd_cnt=%0d blk=%0d, required 64/64/1", wr_q.size(), wrd_cnt, blk_n);
    end
    vec_n++; if (wr_q.size() > 40 && wr_q[40] !== {28'd0, BASE + 36'd40}) begin
      miss_n++; $display("FAIL rm_word40: got %h, required %h", wr_q[40], {28'd0, BASE + 36'd40});
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_to_boundary();
    int bad;
    set_defaults();
    cfg_bound_word = 7;
    run_block(TS_A);
    vec_n++; if (timeout_err !== 1'b0) begin miss_n++; $display("FAIL bd_err: got %0b, required 0", timeout_err); end
    vec_n++; if (wr_q.size() != 64 || blk_n != 1) begin miss_n++; $display("FAIL bd_writes: writes=%0d blk=%0d, required 64/1", wr_q.size(), blk_n); end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== ((i == 0) ? TS_A : {28'd0, BASE + 36'(i)})) bad++;
    vec_n++; if (bad != 0) begin miss_n++; $display("FAIL bd_data: %0d bad words, required 0", bad); end
    vec_n++; if (blk_cyc != 1401) begin miss_n++; $display("FAIL bd_blk_time: cycle %0d, required 1401", blk_cyc); end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0;
    strt_blk_strb = 1'b0; time_stamp = '0; puc_data = '0;
    puc_data_strb = 1'b0; fifo_full = 1'b0;
    set_defaults();
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_to_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
`default_nettype wire
